// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: definitions shared by the UART transmitter and its bench.
//   tx_state_t  : transmitter FSM states (also exported on the debug port)
//   PARITY_*    : encodings for the uart_tx PARITY parameter
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/edge_tick.sv
// edge_tick: one-cycle pulse on each rising edge of a slow level signal that
// lives in the old_clock domain (e.g. a divided clock used as a baud strobe).
//   old_clock : system clock, rising edge
//   reset     : synchronous, active-high; clears the history register
//   level_in  : level to watch (same clock domain, no synchroniser needed)
//   tick_out  : high for the one cycle where level_in is 1 and was 0 last cycle
module edge_tick (
  input  logic old_clock,
  input  logic reset,
  input  logic level_in,
  output logic tick_out
);

  logic level_q;

  always_ff @(posedge old_clock) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_in;
    end
  end

  assign tick_out = level_in & ~level_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: single-byte UART transmitter paced by an external baud level.
//   old_clock : system clock, rising edge
//   reset     : synchronous, active-high; aborts any frame, line goes idle high
//   baud_clk  : divided clock level; each rising edge is one bit-period tick
//   tx_data   : word to send, captured only on acceptance
//   tx_valid  : tx_data holds a word to send
//   tx_ready  : transmitter is idle and accepts a word this cycle
//   tx        : serial line, idle high, start bit, LSB first, parity, stop(s)
//   busy      : a frame is pending or on the line (inverse of tx_ready)
//   state_dbg : current FSM state, for observation only
//
// Handshake: a word is accepted on any old_clock edge where tx_valid and
// tx_ready are both high. tx_ready depends only on the FSM state, never on
// tx_valid. tx_valid may be raised at any time and need not be held once the
// word is accepted; tx_valid and tx_data are ignored while tx_ready is low.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 old_clock,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output tx_state_t            state_dbg
);

  localparam int              CNT_W     = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t            state_q, state_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_n;
  logic                 stop_cnt_q, stop_cnt_n;
  logic                 tx_q, tx_n;
  logic                 par_q, par_n;
  logic                 tick;

  edge_tick u_edge_tick (
    .old_clock (old_clock),
    .reset     (reset),
    .level_in  (baud_clk),
    .tick_out  (tick)
  );

  always_ff @(posedge old_clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      par_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      shift_q    <= shift_n;
      bit_cnt_q  <= bit_cnt_n;
      stop_cnt_q <= stop_cnt_n;
      tx_q       <= tx_n;
      par_q      <= par_n;
    end
  end

  // tx is registered, so every line change lands on the cycle after the tick
  // that caused it. The parity bit is computed at acceptance because the
  // shift register no longer holds the whole word once shifting starts.
  always_comb begin
    state_n    = state_q;
    shift_n    = shift_q;
    bit_cnt_n  = bit_cnt_q;
    stop_cnt_n = stop_cnt_q;
    tx_n       = tx_q;
    par_n      = par_q;
    case (state_q)
      ST_IDLE: begin
        tx_n = 1'b1;
        if (tx_valid) begin
          shift_n    = tx_data;
          par_n      = (PARITY == PARITY_ODD) ? ~(^tx_data) : ^tx_data;
          bit_cnt_n  = '0;
          stop_cnt_n = 1'b0;
          // A tick in this same cycle is deliberately ignored: SYNC waits
          // for the next one so the start bit is a full period.
          state_n    = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (tick) begin
          tx_n    = 1'b0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          tx_n      = shift_q[0];
          shift_n   = shift_q >> 1;
          bit_cnt_n = '0;
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY != PARITY_NONE) begin
              tx_n    = par_q;
              state_n = ST_PARITY;
            end else begin
              tx_n       = 1'b1;
              stop_cnt_n = 1'b0;
              state_n    = ST_STOP;
            end
          end else begin
            tx_n      = shift_q[0];
            shift_n   = shift_q >> 1;
            bit_cnt_n = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          tx_n       = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = ST_STOP;
        end
      end
      ST_STOP: begin
        tx_n = 1'b1;
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_n = ST_IDLE;
          end else begin
            stop_cnt_n = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = ST_IDLE;
      end
    endcase
  end

  assign tx_ready  = (state_q == ST_IDLE);
  assign busy      = ~tx_ready;
  assign tx        = tx_q;
  assign state_dbg = state_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-002 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-003 Parameter STOP_BITS, default 1: stop bits per frame, legal values 1 or 2.
REQ-004 Port old_clock, input, 1: the single system clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port baud_clk, input, 1: divided clock from clk_div new_clock, same clock domain, sampled as a level and never used as a clock.
REQ-007 Port tx_data, input, DATA_BITS: byte to send; sampled only on acceptance.
REQ-008 Port tx_valid, input, 1: tx_data holds a valid byte.
REQ-009 Port tx_ready, output, 1: block can accept a byte this cycle.
REQ-010 Port tx, output, 1: serial line, idle high, LSB first.
REQ-011 Port busy, output, 1: a frame is pending or in progress.

Function
REQ-012 Tick = baud_clk high AND registered previous baud_clk low; the tick lasts one old_clock cycle per baud_clk rising edge.
REQ-013 States: IDLE, SYNC, START, DATA, PARITY, STOP.
REQ-014 tx_ready = 1 only in IDLE; busy = NOT tx_ready.
REQ-015 Acceptance = tx_valid AND tx_ready at an old_clock edge: latch tx_data into the shift register and go to SYNC.
REQ-016 SYNC: tx stays 1; on the next tick, tx becomes 0 and the state goes to START.
REQ-017 START, on tick: tx takes data bit 0, bit counter is cleared, state goes to DATA.
REQ-018 DATA, on tick: shift right and output the next bit; after DATA_BITS bit periods, go to PARITY if PARITY != 0, else go to STOP.
REQ-019 PARITY: the bit is XOR of the latched data bits (even), or its inverse (odd).
REQ-020 STOP: tx = 1 for STOP_BITS tick periods; on the tick that ends the last stop bit, go to IDLE.
REQ-021 Every bit period is exactly one tick-to-tick interval; tx changes only on the cycle after a tick.
REQ-022 Frame length = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bit periods, from the first tick after acceptance.
REQ-023 A tick and acceptance in the same cycle: acceptance happens, and that tick does not start the frame; the frame starts at the following tick.
REQ-024 tx_valid while busy is ignored; tx_data changes after acceptance have no effect.
REQ-025 Back-to-back frames: tx_ready rises the cycle after STOP ends, so the next start bit begins no earlier than the next tick.
REQ-026 If baud_clk is held constant, no tick occurs and the state and tx hold indefinitely.
REQ-027 Bit counter width = clog2(DATA_BITS + 1); it does not wrap within a frame.

Reset
REQ-028 With reset high at an old_clock edge: state = IDLE, tx = 1, tx_ready = 1, busy = 0, shift register = 0, bit and stop counters = 0, previous-baud register = 0.
REQ-029 Reset mid-frame aborts the frame; tx returns to 1 on the first edge with reset high, and no partial bits follow.
REQ-030 Reset takes priority over acceptance and over tick in the same cycle.

Structure
REQ-031 A shared package holds the state enumeration and the PARITY encodings (NONE/EVEN/ODD).
REQ-032 The tick detector is one sub-module, edge_tick (ports old_clock, reset, level_in, tick_out), reused by later serial blocks.
REQ-033 The shift and FSM logic live in uart_tx itself; there is no FIFO.

Verification
REQ-034 Defaults, baud_clk from clk_div with clock_div=4, send 0xA5 -> tx shows 0, 1,0,1,0,0,1,0,1, 1; each bit 4 cycles; busy high for 40 cycles after the first tick.
REQ-035 PARITY=1, send 0x07 -> parity bit 1; PARITY=2, send 0x07 -> parity bit 0.
REQ-036 STOP_BITS=2, tx_valid held high with 0x55 then 0x0F -> two frames with exactly 2 stop periods between them; second start bit on the first tick after tx_ready.
REQ-037 Assert reset during DATA bit 3 -> tx = 1 and tx_ready = 1 at the next edge; a subsequent 0x3C transmits correctly.
REQ-038 Hold baud_clk at 1 after acceptance -> tx stays 1 and state stays SYNC; release -> frame proceeds normally.
REQ-039 Drive tx_valid with 0xFF while busy -> ignored; the line shows only the original frame.
